find_kth_set: RTL

FIND_KTH_SET -- requirements
Module: find_kth_set

---
 rtl/find_kth_set.sv | 135 +++++++++++++
 1 files changed

// File: rtl/find_kth_set.sv
// Locates the k-th (0-based, LSB-first) set bit of a window bitmap by scanning
// it one fixed-width block per cycle. A request is captured in IDLE, scanned in
// SCAN, and the result is held in DONE until the consumer takes it.
module find_kth_set #(
  parameter int WND_SIZE      = 128,
  parameter int BLOCK_WIDTH   = 16,
  parameter int WND_IND_WIDTH = $clog2(WND_SIZE)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [WND_SIZE-1:0]      req_bitmap,
  input  logic [WND_IND_WIDTH-1:0] req_rank,
  output logic                     resp_valid,
  input  logic                     resp_ready,
  output logic                     resp_found,
  output logic [WND_IND_WIDTH-1:0] resp_idx
);

  localparam int NUM_BLOCKS = WND_SIZE / BLOCK_WIDTH;
  localparam int BLK_W      = (NUM_BLOCKS > 1) ? $clog2(NUM_BLOCKS) : 1;
  localparam int POS_W      = (BLOCK_WIDTH > 1) ? $clog2(BLOCK_WIDTH) : 1;
  localparam int CNT_W      = $clog2(BLOCK_WIDTH) + 1;
  // One extra bit so the running rank never wraps while subtracting counts.
  localparam int REM_W      = WND_IND_WIDTH + 1;

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    DONE
  } state_t;

  state_t                   state_reg;
  logic [WND_SIZE-1:0]      bitmap_reg;
  logic [REM_W-1:0]         remaining_reg;
  logic [BLK_W-1:0]         blk_reg;
  logic                     resp_valid_reg;
  logic                     resp_found_reg;
  logic [WND_IND_WIDTH-1:0] resp_idx_reg;

  // Bitmap split into scan blocks; the block pointer picks one per cycle.
  logic [BLOCK_WIDTH-1:0] blocks [NUM_BLOCKS];
  logic [BLOCK_WIDTH-1:0] block_bits;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_BLOCKS; gi++) begin : g_blocks
      assign blocks[gi] = bitmap_reg[gi*BLOCK_WIDTH +: BLOCK_WIDTH];
    end
  endgenerate

  assign block_bits = blocks[blk_reg];

  logic [CNT_W-1:0]         p;
  logic [POS_W-1:0]         pos;
  logic                     hit;
  logic                     last_blk;
  logic [WND_IND_WIDTH-1:0] hit_idx;

  // Popcount of the current block and position of its (remaining)-th set bit.
  always_comb begin
    p   = '0;
    pos = '0;
    for (int i = 0; i < BLOCK_WIDTH; i++) begin
      if (block_bits[i]) begin
        if (REM_W'(p) == remaining_reg) begin
          pos = i[POS_W-1:0];
        end
        p = p + CNT_W'(1);
      end
    end
  end

  assign hit      = remaining_reg < REM_W'(p);
  assign last_blk = blk_reg == BLK_W'(NUM_BLOCKS - 1);
  assign hit_idx  = (WND_IND_WIDTH'(blk_reg) << POS_W) | WND_IND_WIDTH'(pos);

  // Gated by rst_n so the block never advertises readiness while held in reset.
  assign req_ready  = rst_n && (state_reg == IDLE);
  assign resp_valid = resp_valid_reg;
  assign resp_found = resp_found_reg;
  assign resp_idx   = resp_idx_reg;

  // Control FSM: capture request, scan block by block, hold result until taken.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg      <= IDLE;
      bitmap_reg     <= '0;
      remaining_reg  <= '0;
      blk_reg        <= '0;
      resp_valid_reg <= 1'b0;
      resp_found_reg <= 1'b0;
      resp_idx_reg   <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (req_valid) begin
            bitmap_reg    <= req_bitmap;
            remaining_reg <= REM_W'(req_rank);
            blk_reg       <= '0;
            state_reg     <= SCAN;
          end
        end
        SCAN: begin
          if (hit) begin
            resp_found_reg <= 1'b1;
            resp_idx_reg   <= hit_idx;
            resp_valid_reg <= 1'b1;
            state_reg      <= DONE;
          end else begin
            remaining_reg <= remaining_reg - REM_W'(p);
            blk_reg       <= blk_reg + BLK_W'(1);
            if (last_blk) begin
              resp_found_reg <= 1'b0;
              resp_idx_reg   <= '0;
              resp_valid_reg <= 1'b1;
              state_reg      <= DONE;
            end
          end
        end
        DONE: begin
          if (resp_ready) begin
            resp_valid_reg <= 1'b0;
            state_reg      <= IDLE;
          end
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

endmodule
